// File: rtl/bcd_pkg.sv
// Shared constants and types for the sequential binary-to-BCD converter
// that feeds the seven-segment display word.
package bcd_pkg;

  localparam int DIGIT_W         = 4;
  localparam int NUM_DIGITS      = 4;
  localparam int SCRATCH_W       = DIGIT_W * NUM_DIGITS;
  localparam int BCD_OUT_W       = 13;
  localparam int MAX_VAL_DEFAULT = 1999;

  // Field positions inside the packed display word
  localparam int ONE_LSB  = 0;
  localparam int TEN_LSB  = 4;
  localparam int HUN_LSB  = 8;
  localparam int THOU_BIT = 12;

  localparam logic [BCD_OUT_W-1:0] SAT_WORD = 13'h1999;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q
);

  always_comb begin
    q = d;
    if (d >= DIGIT_W'(5))
      q = d + DIGIT_W'(3);
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 converter: one input bit per clock, start/done
// handshake, result held stable on bcd_out between conversions.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W   = 11,
  parameter int MAX_VAL = MAX_VAL_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BIN_W-1:0]     bin_in,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf,
  output logic [BCD_OUT_W-1:0] bcd_out
);

  localparam int                CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(BIN_W - 1);
  localparam logic [BIN_W-1:0]  MAX_B = BIN_W'(MAX_VAL);

  state_t               state;
  logic [BIN_W-1:0]     sr;
  logic [SCRATCH_W-1:0] scratch;
  logic [SCRATCH_W-1:0] adj;
  logic [SCRATCH_W-1:0] next_scratch;
  logic [CNT_W-1:0]     count;
  logic                 sat;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (scratch[i*DIGIT_W +: DIGIT_W]),
      .q (adj[i*DIGIT_W +: DIGIT_W])
    );
  end

  assign next_scratch = {adj[SCRATCH_W-2:0], sr[BIN_W-1]};

  // A digit carried out of the thousands column can only come from an
  // out-of-range input, so it is folded into the saturation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sr      <= '0;
      scratch <= '0;
      count   <= '0;
      sat     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      bcd_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sr      <= bin_in;
            scratch <= '0;
            count   <= '0;
            sat     <= (bin_in > MAX_B);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= next_scratch;
          sr      <= {sr[BIN_W-2:0], 1'b0};
          count   <= count + CNT_W'(1);
          sat     <= sat | adj[SCRATCH_W-1];
          if (count == LAST) begin
            if (sat | adj[SCRATCH_W-1])
              bcd_out <= SAT_WORD;
            else
              bcd_out <= {next_scratch[THOU_BIT],
                          next_scratch[HUN_LSB +: DIGIT_W],
                          next_scratch[TEN_LSB +: DIGIT_W],
                          next_scratch[ONE_LSB +: DIGIT_W]};
            ovf   <= sat | adj[SCRATCH_W-1];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench: stimulus pushes hand-computed results, a negedge monitor
// pops and compares them on every done pulse and checks holding in between.
module tb_bin_to_bcd_seq;

  localparam int BIN_W = 11;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [BIN_W-1:0] bin_in = '0;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [12:0]      bcd_out;

  bin_to_bcd_seq #(.BIN_W(BIN_W), .MAX_VAL(1999)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .bcd_out (bcd_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [12:0] bcd;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          tests = 0;
  int          fails = 0;
  logic [12:0] last_bcd = '0;
  logic        last_ovf = 1'b0;
  int          busy_cnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Waits for IDLE, issues one request and records its expected result.
  task automatic applyStimulus(input logic [BIN_W-1:0] v, input logic [12:0] eb,
                               input logic eo);
    int waitc = 0;
    @(negedge clk);
    while ((busy || done) && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 100) checkOutput("idle_timeout", {30'd0, busy, done}, 0);
    start  = 1'b1;
    bin_in = v;
    @(posedge clk);
    #1;
    exp_q.push_back('{eb, eo, cyc});
    start  = 1'b0;
    bin_in = 11'h5A5;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last_bcd = '0;
      last_ovf = 1'b0;
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done", {31'd0, done}, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("bcd_out", bcd_out, e.bcd);
          checkOutput("ovf", ovf, e.ovf);
          checkOutput("latency", cyc - e.acc, BIN_W);
          checkOutput("busy_cycles", busy_cnt, BIN_W);
        end
        busy_cnt = 0;
        last_bcd = bcd_out;
        last_ovf = ovf;
      end else begin
        checkOutput("hold_bcd", bcd_out, last_bcd);
        checkOutput("hold_ovf", ovf, last_ovf);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  logic [BIN_W-1:0] sweep_in [8] = '{11'd0, 11'd9, 11'd10, 11'd99,
                                     11'd100, 11'd999, 11'd1000, 11'd1999};
  logic [12:0]      sweep_out[8] = '{13'h0000, 13'h0009, 13'h0010, 13'h0099,
                                     13'h0100, 13'h0999, 13'h1000, 13'h1999};

  initial begin
    int waitc;
    repeat (3) @(negedge clk);
    checkOutput("reset_bcd", bcd_out, 13'h0000);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_ovf", ovf, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_done", done, 0);
    end

    applyStimulus(11'd1234, 13'h1234, 1'b0);

    for (int i = 0; i < 8; i++)
      applyStimulus(sweep_in[i], sweep_out[i], 1'b0);

    applyStimulus(11'd2000, 13'h1999, 1'b1);
    applyStimulus(11'd2047, 13'h1999, 1'b1);
    applyStimulus(11'd5,    13'h0005, 1'b0);

    // Requests during SHIFT (edge 3) and on the finishing edge (11) are dropped
    applyStimulus(11'd1234, 13'h1234, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start  = (k == 3 || k == 11);
      bin_in = 11'd777;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    applyStimulus(11'd777, 13'h0777, 1'b0);

    applyStimulus(11'd1500, 13'h1500, 1'b0);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_bcd", bcd_out, 13'h0000);
    checkOutput("abort_ovf", ovf, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    applyStimulus(11'd42, 13'h0042, 1'b0);

    waitc = 0;
    while (exp_q.size() != 0 && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (exp_q.size() != 0) checkOutput("drain_timeout", exp_q.size(), 0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
